div_seq: RTL

- Multi-cycle divide sequencer for the HI/LO datapath of the 5-stage core.
- The ex stage issues DIV/DIVU operands plus a start request. The block runs a radix-2 restoring shift-subtract loop, one bit per cycle.
- It returns {remainder, quotient} for writing to HI/LO.
- While busy_o is high, ex holds its stall request. annul_i lets the pipeline abort an in-flight divide on flush.

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_abs_neg.sv | 12 +
 rtl/div_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encodings and control constants for the divide sequencer
package div_seq_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_abs_neg.sv
// div_abs_neg: combinational two's-complement conditional negate (abs when neg_i is the sign bit)
module div_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divide sequencer returning {remainder, quotient}; optional DIV_ZERO_FLAG_EN adds div_zero_o
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                busy_o
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic                div_zero_o
`endif
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DATA_W);

   div_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
   logic                sa_q, sb_q, sgn_q;
   logic [2*DATA_W-1:0] result_q;
   logic                ready_q, busy_q;
   logic [DATA_W-1:0]   a_abs, b_abs, q_fix, r_fix;
   logic [DATA_W:0]     t_w, diff_w;

   // partial remainder with next dividend bit shifted in, and trial subtraction in DATA_W+1 bits
   assign t_w    = {rem_q, quo_q[DATA_W-1]};
   assign diff_w = t_w - {1'b0, dvs_q};

   div_abs_neg #(.W(DATA_W)) u_abs_a (
      .val_i(opdata1_i), .neg_i(signed_div_i & opdata1_i[DATA_W-1]), .val_o(a_abs)
   );
   div_abs_neg #(.W(DATA_W)) u_abs_b (
      .val_i(opdata2_i), .neg_i(signed_div_i & opdata2_i[DATA_W-1]), .val_o(b_abs)
   );
   div_abs_neg #(.W(DATA_W)) u_fix_q (
      .val_i(quo_q), .neg_i(sgn_q & (sa_q ^ sb_q)), .val_o(q_fix)
   );
   div_abs_neg #(.W(DATA_W)) u_fix_r (
      .val_i(rem_q), .neg_i(sgn_q & sa_q), .val_o(r_fix)
   );

   // control FSM and shift-subtract datapath with registered result/ready/busy
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            DivFree: begin
               result_q <= '0;
               ready_q  <= DivResultNotReady;
               if (start_i == DivStart && !annul_i) begin
                  busy_q <= 1'b1;
                  if (opdata2_i == '0) begin
                     state_q <= DivByZero;
                  end else begin
                     state_q <= DivOn;
                     cnt_q   <= '0;
                     rem_q   <= '0;
                     quo_q   <= a_abs;
                     dvs_q   <= b_abs;
                     sa_q    <= opdata1_i[DATA_W-1];
                     sb_q    <= opdata2_i[DATA_W-1];
                     sgn_q   <= signed_div_i;
                  end
               end
            end
            DivByZero: begin
               busy_q   <= 1'b0;
               result_q <= '0;
               state_q  <= annul_i ? DivFree : DivEnd;
               ready_q  <= annul_i ? DivResultNotReady : DivResultReady;
            end
            DivOn: begin
               if (annul_i) begin
                  state_q  <= DivFree;
                  busy_q   <= 1'b0;
                  result_q <= '0;
               end else if (cnt_q != CntMax) begin
                  rem_q <= diff_w[DATA_W] ? t_w[DATA_W-1:0] : diff_w[DATA_W-1:0];
                  quo_q <= {quo_q[DATA_W-2:0], ~diff_w[DATA_W]};
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  state_q  <= DivEnd;
                  busy_q   <= 1'b0;
                  ready_q  <= DivResultReady;
                  result_q <= {r_fix, q_fix};
               end
            end
            DivEnd: begin
               if (annul_i || start_i == DivStop) begin
                  state_q  <= DivFree;
                  ready_q  <= DivResultNotReady;
                  result_q <= '0;
               end
            end
         endcase
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   logic zero_q;

   // divide-by-zero flag: set leaving BYZERO, held through END, cleared everywhere else
   always_ff @(posedge clk) begin
      if (rst) zero_q <= 1'b0;
      else zero_q <= (state_q == DivByZero && !annul_i) ||
                     (state_q == DivEnd && zero_q && start_i == DivStart && !annul_i);
   end

   assign div_zero_o = zero_q;
`endif

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = busy_q;

endmodule
